wishbone_rr_arbiter: RTL and testbench
======================================

WISHBONE_RR_ARBITER -- requirements
Module: wishbone_rr_arbiter

Interface
REQ-001 The block SHALL take parameter NM, default 4: number of masters, range 2..16.
REQ-002 The block SHALL take parameter DW, default 8: data width.
REQ-003 The block SHALL take parameter AW, default 16: address width.
REQ-004 The block SHALL take parameter TIMEOUT, default 255: stalled-strobe cycles before error; 0 disables the watchdog.
REQ-005 The block SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-007 The block SHALL have port m_dat_i, input, NM*DW: master write data; master k occupies slice k.
REQ-008 The block SHALL have port m_adr_i, input, NM*AW: master addresses, sliced per master.
REQ-009 The block SHALL have ports m_we_i, m_stb_i and m_cyc_i, input, NM each: per-master we, stb and cyc.
REQ-010 The block SHALL have port m_ack_o, output, NM: per-master ack.
REQ-011 The block SHALL have port m_err_o, output, NM: per-master watchdog error pulse.
REQ-012 The block SHALL have ports s_dat_o (DW), s_adr_o (AW), s_we_o, s_stb_o and s_cyc_o (1 each), output: the shared bus towards the slave.
REQ-013 The block SHALL have port s_ack_i, input, 1: ack from the slave.
REQ-014 The block SHALL have port grant_o, output, NM: one-hot owner, all-zero when idle.

Function
REQ-015 The FSM SHALL have two states: IDLE (no owner) and BUSY (owner registered).
REQ-016 In IDLE, if any m_cyc_i bit is high, the block SHALL register as owner the first requester found searching upward from (last_owner+1) mod NM, wrapping, and SHALL enter BUSY on the next edge.
REQ-017 A request raised in cycle k SHALL appear on the s_* bus in cycle k+1 (one-cycle grant latency).
REQ-018 In BUSY, s_dat_o, s_adr_o, s_we_o, s_stb_o and s_cyc_o SHALL equal the owner's slice combinationally.
REQ-019 In IDLE, s_cyc_o, s_stb_o and s_we_o SHALL be 0, and s_dat_o and s_adr_o SHALL be 0.
REQ-020 Ownership SHALL persist while the owner's m_cyc_i is high, regardless of other requests (cycle lock).
REQ-021 When the owner's m_cyc_i is low in BUSY, the block SHALL return to IDLE on that edge and update last_owner to the owner; arbitration then resumes next cycle.
REQ-022 Consequently, at least one idle bus cycle SHALL separate consecutive owners.
REQ-023 m_ack_o[owner] SHALL equal s_ack_i combinationally; all other m_ack_o bits SHALL be 0.
REQ-024 s_ack_i in IDLE SHALL be ignored.
REQ-025 The watchdog counter (width clog2(TIMEOUT+1)) SHALL increment each BUSY cycle with s_stb_o=1 and s_ack_i=0, and SHALL clear on ack, on stb low, or in IDLE.
REQ-026 When the counter reaches TIMEOUT, the block SHALL register m_err_o[owner]=1 for exactly one cycle and clear the counter; ownership SHALL be unchanged.
REQ-027 Ack and timeout in the same cycle: ack SHALL win, with no error pulse.
REQ-028 With TIMEOUT=0, m_err_o SHALL be constantly 0.
REQ-029 grant_o SHALL be a registered one-hot of the owner.

Reset
REQ-030 On rst_i high, the FSM SHALL go to IDLE, last_owner to NM-1 so that master 0 has first priority, and counter, grant_o and m_err_o to 0.
REQ-031 Reset asserted mid-cycle SHALL drop s_cyc_o and s_stb_o immediately (asynchronously) with no ack or err delivered.

Structure
REQ-032 Package wb_arb_pkg SHALL hold the state enum {IDLE, BUSY} and the default parameter constants.
REQ-033 The rotating-priority search SHALL be the sub-module wb_rr_pick (inputs: req[NM], last[clog2 NM]; output: idx and valid), purely combinational.

Verification
REQ-034 Single master: m_cyc_i=0001 with stb at cycle 0 -> grant_o=0001 and s_cyc_o=1 at cycle 1; s_ack_i=1 at cycle 3 -> m_ack_o=0001 at cycle 3 only.
REQ-035 Round-robin: all four m_cyc_i held high, each owner drops cyc after 2 cycles -> grant order 0,1,2,3,0 with one IDLE cycle between each.
REQ-036 Lock: owner 2 active while master 0 requests -> grant stays 0100 until m_cyc_i[2] falls; next owner is 0 after wrap (3 not requesting).
REQ-037 Watchdog: TIMEOUT=4, owner 1 strobes with no ack -> m_err_o=0010 pulse on the 5th stalled cycle, repeating every 5 cycles; ack on the 4th stalled cycle -> no pulse.
REQ-038 Reset mid-cycle: rst_i asserted while BUSY -> s_cyc_o=0 in the same cycle, grant_o=0000; after release with masters 0 and 3 both requesting, master 0 is granted first.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter.
//   arb_state_t : arbiter FSM states (IDLE = no owner, BUSY = owner registered)
//   DEF_*       : default parameter values used by the top level
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_NM      = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_AW      = 16;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority search, purely combinational.
// Finds the first set bit of req searching upward from (last+1) mod NM,
// wrapping around; the previous owner 'last' has the lowest priority.
//   req   : request vector, one bit per master
//   last  : index of the previous owner
//   idx   : index of the selected requester (0 when valid is low)
//   valid : at least one request bit is set
module wb_rr_pick #(
    parameter int NM = 4,
    parameter int LW = $clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int            cand;
        logic [LW-1:0] cand_idx;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Walk from the farthest offset to the nearest so that the nearest
        // requester (smallest offset) is written last and therefore wins.
        for (int off = NM; off >= 1; off--) begin
            cand     = (int'(last) + off) % NM;
            cand_idx = LW'(cand);
            if (req[cand_idx]) begin
                idx   = cand_idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter giving NM Wishbone masters access to one shared slave.
// An owner keeps the bus for as long as it holds cyc; when it drops cyc the
// arbiter spends one idle cycle before granting the next requester.
// A watchdog flags an owner whose strobe has been left unacknowledged.
//
// Handshake: a master requests by raising m_cyc_i[k]; once granted, its
// stb/we/adr/dat are passed straight through to the slave, and the slave's
// s_ack_i is routed back only to the owner. Ack outside ownership is dropped.
//
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   m_dat_i, m_adr_i      : per-master write data / address (slice k = master k)
//   m_we_i, m_stb_i,
//   m_cyc_i               : per-master control
//   m_ack_o               : per-master ack (owner only)
//   m_err_o               : per-master one-cycle watchdog error pulse
//   s_dat_o, s_adr_o,
//   s_we_o, s_stb_o,
//   s_cyc_o               : shared bus towards the slave (zero when idle)
//   s_ack_i               : slave ack
//   grant_o               : registered one-hot owner, zero when idle
module wishbone_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NM      = DEF_NM,
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NM*DW-1:0] m_dat_i,
    input  logic [NM*AW-1:0] m_adr_i,
    input  logic [NM-1:0]   m_we_i,
    input  logic [NM-1:0]   m_stb_i,
    input  logic [NM-1:0]   m_cyc_i,
    output logic [NM-1:0]   m_ack_o,
    output logic [NM-1:0]   m_err_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [AW-1:0]   s_adr_o,
    output logic            s_we_o,
    output logic            s_stb_o,
    output logic            s_cyc_o,
    input  logic            s_ack_i,
    output logic [NM-1:0]   grant_o
);

    localparam int LW = $clog2(NM);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [NM-1:0] ONE = {{(NM-1){1'b0}}, 1'b1};

    arb_state_t     state_q;
    arb_state_t     state_d;
    logic [LW-1:0]  owner_q;
    logic [LW-1:0]  last_q;
    logic [LW-1:0]  pick_idx;
    logic           pick_valid;
    logic [NM-1:0]  grant_q;
    logic [NM-1:0]  err_q;
    logic           owner_cyc;

    wb_rr_pick #(
        .NM (NM),
        .LW (LW)
    ) u_pick (
        .req   (m_cyc_i),
        .last  (last_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_cyc = m_cyc_i[owner_q];

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the owner is locked in until its own cyc falls.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = BUSY;
            BUSY:    if (!owner_cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ownership bookkeeping. last_q resets to NM-1 so master 0 is searched first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= '0;
            last_q  <= LW'(NM - 1);
            grant_q <= '0;
        end else if (state_q == IDLE && pick_valid) begin
            owner_q <= pick_idx;
            grant_q <= ONE << pick_idx;
        end else if (state_q == BUSY && !owner_cyc) begin
            last_q  <= owner_q;
            grant_q <= '0;
        end
    end

    // Output logic: pass the owner's slice through while BUSY, zeros otherwise.
    always_comb begin
        s_dat_o = '0;
        s_adr_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        m_ack_o = '0;
        if (state_q == BUSY) begin
            s_dat_o          = m_dat_i[owner_q*DW +: DW];
            s_adr_o          = m_adr_i[owner_q*AW +: AW];
            s_we_o           = m_we_i[owner_q];
            s_stb_o          = m_stb_i[owner_q];
            s_cyc_o          = owner_cyc;
            m_ack_o[owner_q] = s_ack_i;
        end
    end

    // Watchdog: counts consecutive stalled strobe cycles of the owner. When a
    // stalled cycle finds the count already at TIMEOUT an error pulse is
    // registered and counting restarts; an ack in that cycle suppresses it.
    if (TIMEOUT > 0) begin : g_wdog
        localparam logic [WW-1:0] TO_V = WW'(TIMEOUT);
        logic [WW-1:0] wdog_q;
        logic          stalled;

        assign stalled = (state_q == BUSY) && s_stb_o && !s_ack_i;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wdog_q <= '0;
                err_q  <= '0;
            end else begin
                err_q <= '0;
                if (!stalled) begin
                    wdog_q <= '0;
                end else if (wdog_q == TO_V) begin
                    wdog_q <= '0;
                    err_q  <= ONE << owner_q;
                end else begin
                    wdog_q <= wdog_q + 1'b1;
                end
            end
        end
    end else begin : g_no_wdog
        assign err_q = '0;
    end

    assign m_err_o = err_q;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Bench for wishbone_rr_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level reference model of the arbitration rules.
// Inputs change at the falling edge; outputs are sampled 1 ns later.
module tb_wishbone_rr_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_dat;
    logic [63:0] m_adr;
    logic [3:0]  m_we, m_stb, m_cyc;
    logic        s_ack;

    logic [3:0]  m_ack, m_err, grant;
    logic [7:0]  s_dat;
    logic [15:0] s_adr;
    logic        s_we, s_stb, s_cyc;

    logic [3:0]  z_ack, z_err, z_grant;
    logic [7:0]  z_dat;
    logic [15:0] z_adr;
    logic        z_we, z_stb, z_cyc;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         mdl_owner;
    int         mdl_last;
    int         stall_run;
    logic [3:0] mdl_err;

    always #5 clk = ~clk;

    wishbone_rr_arbiter #(.NM(4), .DW(8), .AW(16), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_dat_i(m_dat), .m_adr_i(m_adr), .m_we_i(m_we), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
        .m_ack_o(m_ack), .m_err_o(m_err),
        .s_dat_o(s_dat), .s_adr_o(s_adr), .s_we_o(s_we), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
        .s_ack_i(s_ack), .grant_o(grant)
    );

    wishbone_rr_arbiter #(.NM(4), .DW(8), .AW(16), .TIMEOUT(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .m_dat_i(m_dat), .m_adr_i(m_adr), .m_we_i(m_we), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
        .m_ack_o(z_ack), .m_err_o(z_err),
        .s_dat_o(z_dat), .s_adr_o(z_adr), .s_we_o(z_we), .s_stb_o(z_stb), .s_cyc_o(z_cyc),
        .s_ack_i(s_ack), .grant_o(z_grant)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        m_cyc = 4'hF; m_stb = 4'hF; m_we = 4'hF; s_ack = 1'b1;
        m_dat = 32'hDEADBEEF; m_adr = 64'h0123456789ABCDEF;
        @(negedge clk); #1;
        n_tests++; if (grant !== 4'h0) begin n_fail++; $display("FAIL reset_grant got=%h exp=0", grant); end
        n_tests++; if (m_err !== 4'h0) begin n_fail++; $display("FAIL reset_err got=%h exp=0", m_err); end
        n_tests++; if (m_ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack got=%h exp=0", m_ack); end
        n_tests++; if ({s_cyc, s_stb, s_we, s_adr, s_dat} !== 27'h0) begin
            n_fail++; $display("FAIL reset_bus got=%h exp=0", {s_cyc, s_stb, s_we, s_adr, s_dat});
        end
        @(negedge clk);
        rst = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        m_cyc = 4'b0001; m_stb = 4'b0001; m_we = 4'b0001;
        m_dat = 32'h000000A5; m_adr = 64'h0000_0000_0000_1234;
        #1;
        n_tests++; if ({grant, s_cyc} !== 5'b0) begin n_fail++; $display("FAIL single_latency got=%b exp=0", {grant, s_cyc}); end
        @(negedge clk); #1;
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant got=%b exp=0001", grant); end
        n_tests++; if ({s_cyc, s_stb, s_we, s_adr, s_dat} !== {3'b111, 16'h1234, 8'hA5}) begin
            n_fail++; $display("FAIL single_bus got=%h exp=%h", {s_cyc, s_stb, s_we, s_adr, s_dat}, {3'b111, 16'h1234, 8'hA5});
        end
        @(negedge clk); #1;
        n_tests++; if (m_ack !== 4'b0) begin n_fail++; $display("FAIL single_noack got=%b exp=0000", m_ack); end
        @(negedge clk); s_ack = 1'b1; #1;
        n_tests++; if (m_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got=%b exp=0001", m_ack); end
        @(negedge clk); s_ack = 1'b0; m_cyc = '0; m_stb = '0; #1;
        n_tests++; if ({m_ack, s_cyc, grant} !== 9'b0000_0_0001) begin
            n_fail++; $display("FAIL single_drop got=%b exp=000000001", {m_ack, s_cyc, grant});
        end
        @(negedge clk); s_ack = 1'b1; #1;
        n_tests++; if ({grant, m_ack, s_cyc, s_stb, s_we, s_adr, s_dat} !== 35'h0) begin
            n_fail++; $display("FAIL single_idle got=%h exp=0", {grant, m_ack, s_cyc, s_stb, s_we, s_adr, s_dat});
        end
        s_ack = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        m_stb = 4'hF; m_adr = 64'h3333_2222_1111_0000;
        for (int t = 0; t < 16; t++) begin
            int         own;
            logic [3:0] exp_g;
            if (t > 0) @(negedge clk);
            own   = ((t - 1) / 3) % 4;
            m_cyc = 4'hF;
            if (t % 3 == 2) m_cyc = 4'hF & ~(4'b1 << own);
            #1;
            exp_g = (t % 3 == 0) ? 4'b0 : (4'b1 << own);
            n_tests++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant t=%0d got=%b exp=%b", t, grant, exp_g); end
            if (t % 3 == 1) begin
                n_tests++; if (s_adr !== 16'(own * 16'h1111)) begin
                    n_fail++; $display("FAIL rr_adr t=%0d got=%h exp=%h", t, s_adr, 16'(own * 16'h1111));
                end
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        m_stb = 4'hF;
        for (int t = 0; t < 10; t++) begin
            logic [3:0] exp_g;
            if (t > 0) @(negedge clk);
            m_cyc = {1'b0, (t < 6), 1'b0, (t >= 2)};
            #1;
            exp_g = (t == 0 || t == 7) ? 4'b0000 : (t < 7) ? 4'b0100 : 4'b0001;
            n_tests++; if (grant !== exp_g) begin n_fail++; $display("FAIL lock_grant t=%0d got=%b exp=%b", t, grant, exp_g); end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        m_cyc = 4'b0010; m_stb = 4'b0010;
        for (int t = 0; t < 27; t++) begin
            logic [3:0] exp_e;
            if (t > 0) @(negedge clk);
            s_ack = (t == 19 || t == 24);
            #1;
            exp_e = (t == 6 || t == 11 || t == 16) ? 4'b0010 : 4'b0000;
            n_tests++; if (m_err !== exp_e) begin n_fail++; $display("FAIL wdog_err t=%0d got=%b exp=%b", t, m_err, exp_e); end
            n_tests++; if (z_err !== 4'b0) begin n_fail++; $display("FAIL wdog_off_err t=%0d got=%b exp=0000", t, z_err); end
            if (t == 19) begin
                n_tests++; if (m_ack !== 4'b0010) begin n_fail++; $display("FAIL wdog_ack got=%b exp=0010", m_ack); end
            end
        end
        s_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_cyc = 4'b0010; m_stb = 4'b0010;
        @(negedge clk); #1;
        n_tests++; if ({grant, s_cyc} !== 5'b0010_1) begin n_fail++; $display("FAIL rstmid_pre got=%b exp=00101", {grant, s_cyc}); end
        #1; s_ack = 1'b1; rst = 1'b1; #1;
        n_tests++; if ({s_cyc, s_stb} !== 2'b00) begin n_fail++; $display("FAIL rstmid_bus got=%b exp=00", {s_cyc, s_stb}); end
        n_tests++; if ({grant, m_ack, m_err} !== 12'h0) begin n_fail++; $display("FAIL rstmid_out got=%h exp=0", {grant, m_ack, m_err}); end
        @(negedge clk); m_cyc = 4'b1001; m_stb = 4'b1001; s_ack = 1'b0; rst = 1'b0; #1;
        n_tests++; if (grant !== 4'b0) begin n_fail++; $display("FAIL rstmid_idle got=%b exp=0000", grant); end
        @(negedge clk); #1;
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first got=%b exp=0001", grant); end
    endtask

    // Advance the reference model across one rising edge using current inputs.
    task automatic model_step();
        logic [3:0] new_err;
        logic [1:0] p;
        new_err = '0;
        if (mdl_owner < 0) begin
            stall_run = 0;
            for (int off = 1; off <= 4 && mdl_owner < 0; off++) begin
                p = 2'((mdl_last + off) % 4);
                if (m_cyc[p]) mdl_owner = int'(p);
            end
        end else begin
            p = 2'(mdl_owner);
            if (m_stb[p] && !s_ack) begin
                stall_run++;
                if (stall_run % (TO + 1) == 0) new_err = 4'b1 << mdl_owner;
            end else begin
                stall_run = 0;
            end
            if (!m_cyc[p]) begin
                mdl_last  = mdl_owner;
                mdl_owner = -1;
            end
        end
        mdl_err = new_err;
    endtask

    task automatic test_random();
        do_reset();
        mdl_owner = -1; mdl_last = 3; stall_run = 0; mdl_err = '0;
        for (int i = 0; i < 600; i++) begin
            logic [26:0] exp_bus;
            logic [3:0]  exp_ack, exp_g;
            logic [1:0]  o;
            if (i > 0) @(negedge clk);
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 7) == 0) m_cyc[k] = ~m_cyc[k];
            m_stb = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            m_we  = 4'($urandom_range(0, 15));
            m_dat = $urandom;
            m_adr = {$urandom, $urandom};
            s_ack = ((i / 50) % 2 == 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
            #1;
            exp_bus = '0; exp_ack = '0; exp_g = '0;
            if (mdl_owner >= 0) begin
                o       = 2'(mdl_owner);
                exp_g   = 4'b1 << mdl_owner;
                exp_bus = {m_cyc[o], m_stb[o], m_we[o], m_adr[mdl_owner*16 +: 16], m_dat[mdl_owner*8 +: 8]};
                exp_ack = s_ack ? exp_g : 4'b0;
            end
            n_tests++; if (grant !== exp_g) begin n_fail++; $display("FAIL rand_grant i=%0d got=%b exp=%b", i, grant, exp_g); end
            n_tests++; if ({s_cyc, s_stb, s_we, s_adr, s_dat} !== exp_bus) begin
                n_fail++; $display("FAIL rand_bus i=%0d got=%h exp=%h", i, {s_cyc, s_stb, s_we, s_adr, s_dat}, exp_bus);
            end
            n_tests++; if (m_ack !== exp_ack) begin n_fail++; $display("FAIL rand_ack i=%0d got=%b exp=%b", i, m_ack, exp_ack); end
            n_tests++; if (m_err !== mdl_err) begin n_fail++; $display("FAIL rand_err i=%0d got=%b exp=%b", i, m_err, mdl_err); end
            n_tests++; if ({z_grant, z_ack, z_err} !== {exp_g, exp_ack, 4'b0}) begin
                n_fail++; $display("FAIL rand_off i=%0d got=%h exp=%h", i, {z_grant, z_ack, z_err}, {exp_g, exp_ack, 4'b0});
            end
            n_tests++; if ({z_cyc, z_stb, z_we, z_adr, z_dat} !== exp_bus) begin
                n_fail++; $display("FAIL rand_off_bus i=%0d got=%h exp=%h", i, {z_cyc, z_stb, z_we, z_adr, z_dat}, exp_bus);
            end
            @(posedge clk);
            model_step();
        end
    endtask

    initial begin
        rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
        m_dat = '0; m_adr = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
